// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//  Instruction-fetch stage. Owns the PC and runs a req/valid handshake with
//  the instruction cache. Holds the IF/ID pipeline register that feeds decode,
//  and applies branch redirects and flushes.
//
//  Parameters
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  bubble word presented to decode on miss/flush/redirect
//
//  Ports
//   clk                     in   rising-edge clock
//   reset                   in   asynchronous, active-low reset
//   EN_REG                  in   IF/ID register enable from decode (0 = stall)
//   flush                   in   squash IF/ID contents
//   branch_taken            in   redirect request from execute
//   branch_target[31:0]     in   redirect PC (word aligned)
//   ic_req                  out  cache request
//   ic_addr[31:0]           out  cache request address
//   ic_valid                in   cache response valid (may coincide with ic_req)
//   ic_rdata[31:0]          in   cache response word
//   block_pipe_instr_cache  out  high while waiting on a cache miss
//   instruction[31:0]       out  IF/ID instruction
//   PCNEXT[31:0]            out  IF/ID PC+4 of that instruction
//   inst_valid              out  1 = real instruction, 0 = bubble
//
//  Optional feature (macro FETCH_PERF_EN)
//   perf_fetched[31:0]      out  count of IF/ID loads with inst_valid=1
//   perf_miss_cyc[31:0]     out  count of cycles with block_pipe_instr_cache=1
//   Both counters reset to 0 and wrap on overflow. With the macro undefined
//   the ports and counters do not exist.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN_REG,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_rdata,
  output logic        block_pipe_instr_cache,
  output logic [31:0] instruction,
  output logic [31:0] PCNEXT,
  output logic        inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_miss_cyc
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // What the IF/ID register does at the next edge
  typedef enum logic [1:0] {
    IFID_KEEP      = 2'd0,
    IFID_BUBBLE    = 2'd1,
    IFID_LOAD_IC   = 2'd2,
    IFID_LOAD_HOLD = 2'd3
  } ifid_op_t;

  state_t      state_p0, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] tgt_p0, tgt_nxt;
  logic [31:0] hold_word_p0;
  logic        hold_ld;
  ifid_op_t    ifid_op;
  logic [31:0] pc_plus4;
  logic [31:0] drain_tgt;

  assign pc_plus4  = pc_p0 + 32'd4;
  // A redirect arriving during DRAIN supersedes the latched target
  assign drain_tgt = branch_taken ? branch_target : tgt_p0;

  // ---- stage p0: FSM state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= S_IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    tgt_nxt   = tgt_p0;
    hold_ld   = 1'b0;
    ifid_op   = IFID_KEEP;
    case (state_p0)
      S_IDLE: begin
        state_nxt = S_FETCH;
        if (branch_taken) begin
          pc_nxt  = branch_target;
          ifid_op = IFID_BUBBLE;
        end else if (flush) begin
          ifid_op = IFID_BUBBLE;
        end
      end
      S_FETCH: begin
        if (branch_taken) begin
          ifid_op = IFID_BUBBLE;
          if (ic_valid) begin
            pc_nxt = branch_target;
          end else begin
            // Request still outstanding: wait for it to complete, then redirect
            tgt_nxt   = branch_target;
            state_nxt = S_DRAIN;
          end
        end else if (ic_valid) begin
          if (EN_REG && !flush) begin
            ifid_op = IFID_LOAD_IC;
            pc_nxt  = pc_plus4;
          end else begin
            // Decode cannot take the word (stall or flush): park it, pc stays
            hold_ld   = 1'b1;
            state_nxt = S_HOLD;
            if (flush) ifid_op = IFID_BUBBLE;
          end
        end else if (EN_REG || flush) begin
          ifid_op = IFID_BUBBLE;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          // Leaving HOLD discards the parked word
          ifid_op   = IFID_BUBBLE;
          pc_nxt    = branch_target;
          state_nxt = S_FETCH;
        end else if (flush) begin
          ifid_op = IFID_BUBBLE;
        end else if (EN_REG) begin
          ifid_op   = IFID_LOAD_HOLD;
          pc_nxt    = pc_plus4;
          state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (EN_REG || flush || branch_taken) ifid_op = IFID_BUBBLE;
        if (branch_taken) tgt_nxt = branch_target;
        if (ic_valid) begin
          // Stale response is dropped here
          pc_nxt    = drain_tgt;
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Cache-side outputs
  always_comb begin
    ic_req                 = (state_p0 == S_FETCH) || (state_p0 == S_DRAIN);
    ic_addr                = pc_p0;
    block_pipe_instr_cache = ((state_p0 == S_FETCH) || (state_p0 == S_DRAIN)) && !ic_valid;
  end

  // ---- stage p0: pc, redirect target and hold word ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0        <= RESET_PC;
      tgt_p0       <= 32'd0;
      hold_word_p0 <= 32'd0;
    end else begin
      pc_p0  <= pc_nxt;
      tgt_p0 <= tgt_nxt;
      if (hold_ld) hold_word_p0 <= ic_rdata;
    end
  end

  // ---- stage p1: IF/ID register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction <= NOP_INSTR;
      PCNEXT      <= 32'd0;
      inst_valid  <= 1'b0;
    end else begin
      case (ifid_op)
        IFID_BUBBLE: begin
          instruction <= NOP_INSTR;
          PCNEXT      <= 32'd0;
          inst_valid  <= 1'b0;
        end
        IFID_LOAD_IC: begin
          instruction <= ic_rdata;
          PCNEXT      <= pc_plus4;
          inst_valid  <= 1'b1;
        end
        IFID_LOAD_HOLD: begin
          instruction <= hold_word_p0;
          PCNEXT      <= pc_plus4;
          inst_valid  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched  <= 32'd0;
      perf_miss_cyc <= 32'd0;
    end else begin
      if ((ifid_op == IFID_LOAD_IC) || (ifid_op == IFID_LOAD_HOLD))
        perf_fetched <= perf_fetched + 32'd1;
      if (block_pipe_instr_cache)
        perf_miss_cyc <= perf_miss_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        EN_REG;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_rdata;
  logic        block_pipe_instr_cache;
  logic [31:0] instruction;
  logic [31:0] PCNEXT;
  logic        inst_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_miss_cyc;
`endif

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk                    (clk),
    .reset                  (reset),
    .EN_REG                 (EN_REG),
    .flush                  (flush),
    .branch_taken           (branch_taken),
    .branch_target          (branch_target),
    .ic_req                 (ic_req),
    .ic_addr                (ic_addr),
    .ic_valid               (ic_valid),
    .ic_rdata               (ic_rdata),
    .block_pipe_instr_cache (block_pipe_instr_cache),
    .instruction            (instruction),
    .PCNEXT                 (PCNEXT),
    .inst_valid             (inst_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched           (perf_fetched),
    .perf_miss_cyc          (perf_miss_cyc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Apply one cycle of inputs just after a rising edge; checks follow the call.
  task automatic drive(input logic v, input logic [31:0] d, input logic en,
                       input logic fl, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    ic_valid      = v;
    ic_rdata      = d;
    EN_REG        = en;
    flush         = fl;
    branch_taken  = br;
    branch_target = tgt;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; EN_REG = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = 32'd0; ic_valid = 1'b0; ic_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h exp=0", ic_req); end
    total++; if (block_pipe_instr_cache !== 1'b0) begin bad++; $display("FAIL rst_block got=%h exp=0", block_pipe_instr_cache); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instruction); end
    total++; if (PCNEXT !== 32'h0) begin bad++; $display("FAIL rst_pcnext got=%h exp=0", PCNEXT); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", inst_valid); end
  endtask

  task automatic test_hits;
    @(posedge clk);
    #1;
    reset = 1'b1; ic_valid = 1'b1; EN_REG = 1'b1; ic_rdata = 32'hA000_0000;
    #1;
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%h exp=0", ic_req); end
    drive(1'b1, 32'hA000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (ic_req !== 1'b1) begin bad++; $display("FAIL hit_req got=%h exp=1", ic_req); end
    total++; if (ic_addr !== 32'h1000) begin bad++; $display("FAIL hit_addr0 got=%h exp=1000", ic_addr); end
    drive(1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (instruction !== 32'hA000_0000) begin bad++; $display("FAIL hit_instr0 got=%h exp=a0000000", instruction); end
    total++; if (PCNEXT !== 32'h1004) begin bad++; $display("FAIL hit_pcnext0 got=%h exp=1004", PCNEXT); end
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL hit_valid0 got=%h exp=1", inst_valid); end
    total++; if (ic_addr !== 32'h1004) begin bad++; $display("FAIL hit_addr1 got=%h exp=1004", ic_addr); end
    drive(1'b1, 32'hA000_0002, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (instruction !== 32'hA000_0001) begin bad++; $display("FAIL hit_instr1 got=%h exp=a0000001", instruction); end
    total++; if (PCNEXT !== 32'h1008) begin bad++; $display("FAIL hit_pcnext1 got=%h exp=1008", PCNEXT); end
    total++; if (ic_addr !== 32'h1008) begin bad++; $display("FAIL hit_addr2 got=%h exp=1008", ic_addr); end
  endtask

  task automatic test_miss;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (PCNEXT !== 32'h100C) begin bad++; $display("FAIL hit_pcnext2 got=%h exp=100c", PCNEXT); end
    total++; if (instruction !== 32'hA000_0002) begin bad++; $display("FAIL hit_instr2 got=%h exp=a0000002", instruction); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      total++; if (block_pipe_instr_cache !== 1'b1) begin bad++; $display("FAIL miss_block%0d got=%h exp=1", i, block_pipe_instr_cache); end
      total++; if (ic_addr !== 32'h100C) begin bad++; $display("FAIL miss_addr%0d got=%h exp=100c", i, ic_addr); end
      if (i > 0) begin
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL miss_bubble%0d got=%h exp=0", i, inst_valid); end
      end
    end
    drive(1'b1, 32'hA000_0003, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL miss_bubble3 got=%h exp=0", inst_valid); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL miss_nop got=%h exp=0", instruction); end
    total++; if (block_pipe_instr_cache !== 1'b0) begin bad++; $display("FAIL miss_unblock got=%h exp=0", block_pipe_instr_cache); end
    total++; if (ic_addr !== 32'h100C) begin bad++; $display("FAIL miss_addr3 got=%h exp=100c", ic_addr); end
`ifdef FETCH_PERF_EN
    total++; if (perf_miss_cyc !== 32'd3) begin bad++; $display("FAIL perf_miss got=%0d exp=3", perf_miss_cyc); end
    total++; if (perf_fetched !== 32'd3) begin bad++; $display("FAIL perf_fetched got=%0d exp=3", perf_fetched); end
`endif
  endtask

  task automatic test_hold;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (instruction !== 32'hA000_0003) begin bad++; $display("FAIL hold_prev_instr got=%h exp=a0000003", instruction); end
    total++; if (PCNEXT !== 32'h1010) begin bad++; $display("FAIL hold_prev_pcnext got=%h exp=1010", PCNEXT); end
    total++; if (ic_addr !== 32'h1010) begin bad++; $display("FAIL hold_addr got=%h exp=1010", ic_addr); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL hold_req0 got=%h exp=0", ic_req); end
    total++; if (instruction !== 32'hA000_0003) begin bad++; $display("FAIL hold_stall_instr got=%h exp=a0000003", instruction); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL hold_req1 got=%h exp=0", ic_req); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (instruction !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hold_instr got=%h exp=deadbeef", instruction); end
    total++; if (PCNEXT !== 32'h1014) begin bad++; $display("FAIL hold_pcnext got=%h exp=1014", PCNEXT); end
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%h exp=1", inst_valid); end
    total++; if (ic_addr !== 32'h1014) begin bad++; $display("FAIL hold_next_addr got=%h exp=1014", ic_addr); end
  endtask

  task automatic test_drain;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h2800);
    total++; if (block_pipe_instr_cache !== 1'b1) begin bad++; $display("FAIL drain_block0 got=%h exp=1", block_pipe_instr_cache); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h2000);
    total++; if (ic_req !== 1'b1) begin bad++; $display("FAIL drain_req got=%h exp=1", ic_req); end
    total++; if (ic_addr !== 32'h1014) begin bad++; $display("FAIL drain_addr got=%h exp=1014", ic_addr); end
    total++; if (block_pipe_instr_cache !== 1'b1) begin bad++; $display("FAIL drain_block1 got=%h exp=1", block_pipe_instr_cache); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL drain_bubble got=%h exp=0", inst_valid); end
    drive(1'b1, 32'h5EA1_E000, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (block_pipe_instr_cache !== 1'b0) begin bad++; $display("FAIL drain_unblock got=%h exp=0", block_pipe_instr_cache); end
    drive(1'b1, 32'hB000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (ic_addr !== 32'h2000) begin bad++; $display("FAIL drain_target got=%h exp=2000", ic_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL drain_stale_valid got=%h exp=0", inst_valid); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL drain_stale_instr got=%h exp=0", instruction); end
  endtask

  task automatic test_flush_branch;
    drive(1'b1, 32'hB000_0001, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (instruction !== 32'hB000_0000) begin bad++; $display("FAIL br_instr0 got=%h exp=b0000000", instruction); end
    total++; if (PCNEXT !== 32'h2004) begin bad++; $display("FAIL br_pcnext0 got=%h exp=2004", PCNEXT); end
    drive(1'b1, 32'hB000_0002, 1'b1, 1'b1, 1'b1, 32'h3000);
    total++; if (ic_addr !== 32'h2008) begin bad++; $display("FAIL br_addr got=%h exp=2008", ic_addr); end
    drive(1'b1, 32'hC000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL br_bubble got=%h exp=0", inst_valid); end
    total++; if (PCNEXT !== 32'h0) begin bad++; $display("FAIL br_bubble_pc got=%h exp=0", PCNEXT); end
    total++; if (ic_addr !== 32'h3000) begin bad++; $display("FAIL br_target got=%h exp=3000", ic_addr); end
    drive(1'b1, 32'hC000_0001, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (instruction !== 32'hC000_0000) begin bad++; $display("FAIL br_first_instr got=%h exp=c0000000", instruction); end
    total++; if (PCNEXT !== 32'h3004) begin bad++; $display("FAIL br_first_pcnext got=%h exp=3004", PCNEXT); end
  endtask

  task automatic test_flush_only;
    drive(1'b1, 32'hC000_0002, 1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (PCNEXT !== 32'h3008) begin bad++; $display("FAIL fl_prev_pcnext got=%h exp=3008", PCNEXT); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fl_bubble got=%h exp=0", inst_valid); end
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL fl_hold_req got=%h exp=0", ic_req); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (instruction !== 32'hC000_0002) begin bad++; $display("FAIL fl_kept_instr got=%h exp=c0000002", instruction); end
    total++; if (PCNEXT !== 32'h300C) begin bad++; $display("FAIL fl_kept_pcnext got=%h exp=300c", PCNEXT); end
    total++; if (ic_addr !== 32'h300C) begin bad++; $display("FAIL fl_next_addr got=%h exp=300c", ic_addr); end
  endtask

  task automatic test_reset_hold;
    drive(1'b1, 32'hC000_0003, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    ic_valid = 1'b0;
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL rh_in_hold got=%h exp=0", ic_req); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rh_instr got=%h exp=0", instruction); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rh_valid got=%h exp=0", inst_valid); end
    total++; if (PCNEXT !== 32'h0) begin bad++; $display("FAIL rh_pcnext got=%h exp=0", PCNEXT); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetched !== 32'd0) begin bad++; $display("FAIL rh_perf got=%0d exp=0", perf_fetched); end
`endif
    @(posedge clk);
    #1;
    reset = 1'b1; ic_valid = 1'b1; EN_REG = 1'b1; ic_rdata = 32'hD000_0000;
    #1;
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL rh_idle got=%h exp=0", ic_req); end
    drive(1'b1, 32'hD000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (ic_addr !== 32'h1000) begin bad++; $display("FAIL rh_first_addr got=%h exp=1000", ic_addr); end
    total++; if (ic_req !== 1'b1) begin bad++; $display("FAIL rh_first_req got=%h exp=1", ic_req); end
  endtask

  task automatic test_wrap;
    drive(1'b1, 32'hE000_0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 32'hE000_0001, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (ic_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", ic_addr); end
    drive(1'b1, 32'hE000_0002, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (instruction !== 32'hE000_0001) begin bad++; $display("FAIL wrap_instr got=%h exp=e0000001", instruction); end
    total++; if (PCNEXT !== 32'h0) begin bad++; $display("FAIL wrap_pcnext got=%h exp=0", PCNEXT); end
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%h exp=1", inst_valid); end
    total++; if (ic_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0", ic_addr); end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_hold();
    test_drain();
    test_flush_branch();
    test_flush_only();
    test_reset_hold();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
